timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 161 ++++++++++++++++
 tb/tb_timer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer -- 8-bit APB up/down timer with programmable prescaler.
//
// Registers (APB, zero wait states):
//   0x00 TDR  R/W  load value
//   0x01 TCR  R/W  [7] load, [5] updown (1 = down), [4] en, [1:0] cks
//   0x02 TSR  R/W0 [0] OVF, [1] UDF (sticky, cleared by writing 0)
//   0x03 TCNT R    counter value
//   other        reads 8'h00, writes ignored
//
// Ports:
//   sys_clk  in   clock, rising edge
//   sys_rst  in   asynchronous active-high reset
//   psel     in   APB select
//   penable  in   APB access phase
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [7:0] register address
//   pwdata   in   [7:0] write data
//   prdata   out  [7:0] read data (combinational, 0 outside read access)
//   pready   out  high during every access phase
//   pslverr  out  always 0
//   tmr_ovf  out  TSR.OVF
//   tmr_udf  out  TSR.UDF
// -----------------------------------------------------------------------------
module timer (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic       tmr_ovf,
    output logic       tmr_udf
);

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;
    localparam logic [7:0] TCR_MASK  = 8'hB3;

    logic [7:0] r_tdr;
    logic [7:0] r_tcr;
    logic [7:0] r_tcnt;
    logic [3:0] r_div;
    logic       r_ovf;
    logic       r_udf;

    logic       w_access;
    logic       w_wr;
    logic       w_rd;
    logic       w_load;
    logic       w_updown;
    logic       w_en;
    logic [1:0] w_cks;
    logic [3:0] w_div_max;
    logic       w_run;
    logic       w_tick;
    logic       w_wrap_up;
    logic       w_wrap_dn;
    logic       w_tsr_wr;

    assign w_access = psel & penable;
    assign w_wr     = w_access & pwrite;
    assign w_rd     = w_access & ~pwrite;

    assign w_load   = r_tcr[7];
    assign w_updown = r_tcr[5];
    assign w_en     = r_tcr[4];
    assign w_cks    = r_tcr[1:0];

    // Terminal divider value: tick period is 2^(cks+1) cycles.
    always_comb begin
        w_div_max = 4'd1;
        case (w_cks)
            2'd0: w_div_max = 4'd1;
            2'd1: w_div_max = 4'd3;
            2'd2: w_div_max = 4'd7;
            2'd3: w_div_max = 4'd15;
            default: w_div_max = 4'd1;
        endcase
    end

    assign w_run = w_en & ~w_load;
    // >= rather than == so lowering cks mid-period ticks promptly
    // instead of waiting for the 4-bit divider to wrap.
    assign w_tick    = w_run & (r_div >= w_div_max);
    assign w_wrap_up = w_tick & ~w_updown & (r_tcnt == 8'hFF);
    assign w_wrap_dn = w_tick &  w_updown & (r_tcnt == 8'h00);
    assign w_tsr_wr  = w_wr & (paddr == ADDR_TSR);

    // Register writes
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tdr <= '0;
            r_tcr <= '0;
        end else if (w_wr) begin
            if (paddr == ADDR_TDR) r_tdr <= pwdata;
            if (paddr == ADDR_TCR) r_tcr <= pwdata & TCR_MASK;
        end
    end

    // Prescaler: held at zero unless actively counting
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_div <= '0;
        end else if (!w_run || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    // Counter
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tcnt <= '0;
        end else if (w_load) begin
            r_tcnt <= r_tdr;
        end else if (w_tick) begin
            if (w_updown) r_tcnt <= r_tcnt - 8'd1;
            else          r_tcnt <= r_tcnt + 8'd1;
        end
    end

    // Sticky flags: a software write of 0 clears, a hardware set in the
    // same cycle takes priority over that clear.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_wrap_up | (r_ovf & ~(w_tsr_wr & ~pwdata[0]));
            r_udf <= w_wrap_dn | (r_udf & ~(w_tsr_wr & ~pwdata[1]));
        end
    end

    // Read mux
    always_comb begin
        prdata = 8'h00;
        if (w_rd && !sys_rst) begin
            case (paddr)
                ADDR_TDR:  prdata = r_tdr;
                ADDR_TCR:  prdata = r_tcr;
                ADDR_TSR:  prdata = {6'b0, r_udf, r_ovf};
                ADDR_TCNT: prdata = r_tcnt;
                default:   prdata = 8'h00;
            endcase
        end
    end

    assign pready  = w_access;
    assign pslverr = 1'b0;
    assign tmr_ovf = r_ovf;
    assign tmr_udf = r_udf;

endmodule

// File: tb/tb_timer.sv
module tb_timer;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       psel    = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite  = 1'b0;
    logic [7:0] paddr   = 8'h00;
    logic [7:0] pwdata  = 8'h00;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       tmr_ovf;
    logic       tmr_udf;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        rd_ready;

    timer dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    localparam int unsigned NVEC = 24;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge sys_clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge sys_clk);
        penable = 1'b1;
        @(posedge sys_clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge sys_clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge sys_clk);
        penable = 1'b1;
        #1;
        d = prdata;
        rd_ready = pready;
        @(posedge sys_clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Hold a TSR read access and return the number of edges after the
    // preceding write edge at which the selected flag bit first reads 1.
    task automatic scan_flag(input int unsigned bitn, input int unsigned limit,
                             output int unsigned first);
        logic [7:0] v;
        first = 32'hFFFF_FFFF;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h02;
        for (int unsigned k = 0; k <= limit; k++) begin
            @(negedge sys_clk);
            v = prdata;
            if (v[bitn]) begin
                first = k;
                break;
            end
        end
    endtask

    initial begin
        logic [7:0]  rd;
        int unsigned first;
        int unsigned d;

        vecs = '{
            '{1'b0, 8'h00, 8'h00, 8'h00},
            '{1'b0, 8'h01, 8'h00, 8'h00},
            '{1'b0, 8'h02, 8'h00, 8'h00},
            '{1'b0, 8'h03, 8'h00, 8'h00},
            '{1'b0, 8'h04, 8'h00, 8'h00},
            '{1'b1, 8'h00, 8'hA5, 8'h00},
            '{1'b0, 8'h00, 8'h00, 8'hA5},
            '{1'b1, 8'h01, 8'hFF, 8'h00},
            '{1'b0, 8'h01, 8'h00, 8'hB3},
            '{1'b0, 8'h03, 8'h00, 8'hA5},
            '{1'b1, 8'h01, 8'h00, 8'h00},
            '{1'b0, 8'h01, 8'h00, 8'h00},
            '{1'b1, 8'h04, 8'h55, 8'h00},
            '{1'b0, 8'h04, 8'h00, 8'h00},
            '{1'b0, 8'h00, 8'h00, 8'hA5},
            '{1'b1, 8'h03, 8'h12, 8'h00},
            '{1'b0, 8'h03, 8'h00, 8'hA5},
            '{1'b1, 8'h02, 8'hFF, 8'h00},
            '{1'b0, 8'h02, 8'h00, 8'h00},
            '{1'b1, 8'h00, 8'h3C, 8'h00},
            '{1'b0, 8'h00, 8'h00, 8'h3C},
            '{1'b0, 8'h03, 8'h00, 8'hA5},
            '{1'b1, 8'h01, 8'h4C, 8'h00},
            '{1'b0, 8'h01, 8'h00, 8'h00}
        };

        // Reset
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_ovf", {15'd0, tmr_ovf}, 16'd0);
        check("rst_udf", {15'd0, tmr_udf}, 16'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("idle_pready", {15'd0, pready}, 16'd0);
        check("pslverr", {15'd0, pslverr}, 16'd0);

        // Register map vectors
        for (int unsigned i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                apb_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_addr%02h", i, vecs[i].addr), {8'd0, rd}, {8'd0, vecs[i].exp});
                check($sformatf("vec%0d_pready", i), {15'd0, rd_ready}, 16'd1);
            end
        end

        // Count-up overflow timing over random load values
        for (int unsigned n = 0; n < 100; n++) begin
            d = $urandom_range(253, 0);
            apb_write(8'h01, 8'h00);
            apb_write(8'h02, 8'h00);
            apb_write(8'h00, d[7:0]);
            apb_write(8'h01, 8'h80);
            apb_write(8'h01, 8'h10);
            scan_flag(0, 600, first);
            psel = 1'b0; penable = 1'b0;
            check($sformatf("ovf_time_d%0d", d), first[15:0], 16'((256 - d) * 2));
        end

        // Count-down underflow with cks = 01
        apb_write(8'h01, 8'h00);
        apb_write(8'h02, 8'h00);
        apb_write(8'h00, 8'h03);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h31);
        scan_flag(1, 100, first);
        check("udf_time", first[15:0], 16'd16);
        paddr = 8'h03;
        #1;
        check("udf_tcnt", {8'd0, prdata}, 16'h00FF);
        check("udf_pin", {15'd0, tmr_udf}, 16'd1);
        check("udf_no_ovf", {15'd0, tmr_ovf}, 16'd0);
        psel = 1'b0; penable = 1'b0;

        // Set beats simultaneous software clear
        apb_write(8'h01, 8'h00);
        apb_write(8'h02, 8'h00);
        apb_read(8'h02, rd);
        check("tsr_cleared", {8'd0, rd}, 16'h0000);
        apb_write(8'h00, 8'hFF);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        apb_write(8'h02, 8'h00);
        apb_write(8'h01, 8'h00);
        apb_read(8'h02, rd);
        check("set_wins", {8'd0, rd}, 16'h0001);

        // Flag clear semantics
        apb_write(8'h02, 8'h01);
        apb_read(8'h02, rd);
        check("w1_no_clear", {8'd0, rd}, 16'h0001);
        check("w1_pin", {15'd0, tmr_ovf}, 16'd1);
        apb_write(8'h02, 8'h00);
        apb_read(8'h02, rd);
        check("w0_clear", {8'd0, rd}, 16'h0000);
        check("w0_pin", {15'd0, tmr_ovf}, 16'd0);

        // Load hold
        apb_write(8'h00, 8'h77);
        apb_write(8'h01, 8'h90);
        repeat (20) @(posedge sys_clk);
        apb_read(8'h03, rd);
        check("load_hold", {8'd0, rd}, 16'h0077);
        apb_write(8'h00, 8'h88);
        apb_read(8'h03, rd);
        check("load_follow", {8'd0, rd}, 16'h0088);

        // Pause: 5 ticks from 0x10, then en = 0
        apb_write(8'h01, 8'h00);
        apb_write(8'h00, 8'h10);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        repeat (9) @(posedge sys_clk);
        apb_write(8'h01, 8'h00);
        apb_read(8'h03, rd);
        check("pause_val", {8'd0, rd}, 16'h0015);
        repeat (50) @(posedge sys_clk);
        apb_read(8'h03, rd);
        check("pause_hold", {8'd0, rd}, 16'h0015);

        // Reset mid-count
        apb_write(8'h00, 8'hFE);
        apb_write(8'h01, 8'h80);
        apb_write(8'h01, 8'h10);
        repeat (6) @(posedge sys_clk);
        apb_read(8'h02, rd);
        check("pre_rst_ovf", {8'd0, rd}, 16'h0001);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h03;
        @(negedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_ovf", {15'd0, tmr_ovf}, 16'd0);
        check("async_prdata", {8'd0, prdata}, 16'h0000);
        psel = 1'b0; penable = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (20) @(posedge sys_clk);
        apb_read(8'h03, rd);
        check("post_rst_tcnt", {8'd0, rd}, 16'h0000);
        apb_read(8'h01, rd);
        check("post_rst_tcr", {8'd0, rd}, 16'h0000);
        apb_read(8'h00, rd);
        check("post_rst_tdr", {8'd0, rd}, 16'h0000);
        apb_read(8'h02, rd);
        check("post_rst_tsr", {8'd0, rd}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
